rand_scheduler: RTL and testbench
=================================

# rand_scheduler

Round-robin scheduler that shares one pseudo-random source among up to `N_REQ` requesters in the VGA/SIMD display path, such as sprite placement, colour selection and noise fill. It owns a 16-bit Galois LFSR, arbitrates requests fairly and returns one `OUT_W`-bit random value per grant. It also supports runtime reseeding so that test runs and frames are reproducible.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `OUT_W`, 2: width of the random value delivered per grant, 1..16.
- `SEED`, 16'hACE1: LFSR value loaded on reset. It also replaces any zero `seed_in`.

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `req`  in  `N_REQ`: level request lines. A requester holds its line high until it sees its `gnt` bit.
- `reseed`  in  1: single-cycle pulse; load `seed_in` into the LFSR.
- `seed_in`  in  16: new seed, sampled when `reseed`=1.
- `gnt`  out  `N_REQ`: registered one-hot grant, high for one cycle.
- `rand_valid`  out  1: registered; high in the same cycle as any `gnt` bit.
- `rand_out`  out  `OUT_W`: registered random value. It is meaningful only while `rand_valid`=1 and holds its last value otherwise.

## Operation
- LFSR: 16-bit Galois, right-shift, tap mask 16'hB400.
  - Each step: `lsb = s[0]; s = s >> 1; if (lsb) s ^= 16'hB400`.
  - The LFSR steps on every rising edge with `rst`=1 and `reseed`=0, free-running regardless of grants.
- FSM has two states, `IDLE` and `GRANT`.
- `IDLE`:
  - If `reseed`=1: load the LFSR and stay in `IDLE`; no grant is issued this cycle.
  - Else if `req`≠0: choose a winner by round-robin from `ptr`, meaning the first set bit scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - Register `gnt`=onehot(winner), `rand_valid`=1 and `rand_out`=LFSR[`OUT_W`-1:0] (the pre-step value).
  - Set `ptr` = winner+1 mod `N_REQ`, then go to `GRANT`.
- `GRANT`: clear `gnt` and `rand_valid`, then return to `IDLE`.
  - `req` is ignored in this state.
  - `reseed` in this state is still honoured for the LFSR load.
- Consequences:
  - At most one grant every 2 cycles.
  - The LFSR advances at least 2 steps between consecutive values.
- Reseed details:
  - `reseed` has priority over arbitration in the same cycle.
  - `seed_in`=0 loads `SEED` instead, which prevents LFSR lockup.
  - `ptr` is unaffected by reseed.
- A request dropped before its grant is simply not served. No state is kept per requester.

## Timing
- Reset (`rst`=0 at a rising edge): LFSR=`SEED`, state=`IDLE`, `ptr`=0 (requester 0 has highest priority), `gnt`=0, `rand_valid`=0, `rand_out`=0.
- Reset mid-`GRANT`: outputs clear on that edge. No partial grant survives.
- Latency: `req` sampled at edge *t* in `IDLE` produces `gnt`/`rand_valid`/`rand_out` valid from edge *t* to edge *t*+1. That is one cycle of registered latency and one cycle of pulse width.
- Reseed: `seed_in` sampled at edge *t*. The value after edge *t* is the seed itself. The first grant can sample it at edge *t*+1.
- Throughput: one grant per 2 cycles with `req` continuously nonzero. Under full load each requester is served once every 2·`N_REQ` cycles.

## Test plan
- Reset, then hold `req`=0001 from the first edge with `rst`=1 (edge 1).
  - Edge 1: `gnt`=0001, `rand_out`=2'b01 (from LFSR 16'hACE1).
  - Edge 3: `gnt`=0001, `rand_out`=2'b00 (from LFSR 16'h7138).
  - Between grants `gnt`=0 and `rand_valid`=0.
- Reset, then hold `req`=1111.
  - Grants at edges 1,3,5,7,9 are 0001,0010,0100,1000,0001.
  - `gnt` is never more than one-hot.
- Reset, then hold `req`=1010.
  - Grants alternate 0010,1000,0010.
  - Requesters 0 and 2 are never granted.
- Reseed path:
  - `reseed`=1 with `seed_in`=16'h0001 at edge *t* and `req`=0001: no grant at edge *t*.
  - Edge *t*+1 grants with `rand_out`=2'b01.
  - Repeating with `seed_in`=0 yields the same values as the post-reset sequence (`SEED` substitution).
- Assert `rst`=0 in the `GRANT` cycle: on that edge `gnt`=0, `rand_valid`=0, `rand_out`=0 and `ptr`=0. The next grant with `req`=1111 goes to requester 0.
- Run 65535 idle cycles after reset: the LFSR returns to 16'hACE1 (maximal period) and never reaches 0.

Source files
------------

// File: rtl/rand_scheduler.sv
// rand_scheduler: shares one 16-bit Galois LFSR among N_REQ requesters.
// Requests are served round-robin, one grant per two cycles, and each
// grant delivers an OUT_W-bit slice of the LFSR taken before it steps.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   req         level request lines, one per requester
//   reseed      single-cycle pulse, loads seed_in (zero seed -> SEED)
//   seed_in     new LFSR seed
//   gnt         registered one-hot grant pulse
//   rand_valid  registered, high together with any gnt bit
//   rand_out    registered random value, holds between grants
module rand_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OUT_W = 2,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             reseed,
  input  logic [15:0]      seed_in,
  output logic [N_REQ-1:0] gnt,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_out
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d, lfsr_step;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_d;
  logic               valid_d;
  logic [OUT_W-1:0]   rand_d;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;
  logic               found;

  // Free-running LFSR; reseed overrides the step, zero seed is replaced
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    if (reseed) lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
    else        lfsr_d = lfsr_step;
  end

  // Round-robin pick: first set request scanning upward from ptr
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    rand_d  = rand_out;
    case (state_q)
      IDLE: begin
        if (!reseed && found) begin
          gnt_d   = N_REQ'(1) << win;
          valid_d = 1'b1;
          rand_d  = lfsr_q[OUT_W-1:0];
          ptr_d   = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      ptr_q      <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      ptr_q      <= ptr_d;
      gnt        <= gnt_d;
      rand_valid <= valid_d;
      rand_out   <= rand_d;
    end
  end

endmodule

// File: tb/tb_rand_scheduler.sv
// Testbench for rand_scheduler: directed checks plus a scoreboard fed by a
// behavioural model of the arbitration and LFSR.
module tb_rand_scheduler;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned OUT_W = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             reseed = 1'b0;
  logic [15:0]      seed_in = '0;
  logic [N_REQ-1:0] gnt;
  logic             rand_valid;
  logic [OUT_W-1:0] rand_out;

  int errors = 0;
  int checks = 0;

  rand_scheduler #(.N_REQ(N_REQ), .OUT_W(OUT_W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .req(req), .reseed(reseed), .seed_in(seed_in),
    .gnt(gnt), .rand_valid(rand_valid), .rand_out(rand_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N_REQ+OUT_W-1:0] exp_q[$];
  logic [15:0]            m_lfsr = SEED;
  int                     m_ptr  = 0;
  bit                     m_busy = 0;
  logic [OUT_W-1:0]       m_last = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_lfsr = SEED;
      m_ptr  = 0;
      m_busy = 0;
      m_last = '0;
    end else begin
      bit granted;
      granted = 0;
      if (!m_busy && !reseed && req != 0) begin
        int w;
        w = -1;
        for (int k = 0; k < int'(N_REQ); k++) begin
          int c;
          c = (m_ptr + k) % int'(N_REQ);
          if (w < 0 && req[c]) w = c;
        end
        begin
          logic [N_REQ-1:0] g;
          g = '0;
          g[w] = 1'b1;
          m_last = m_lfsr[OUT_W-1:0];
          exp_q.push_back({g, m_last});
        end
        m_ptr   = (w + 1) % int'(N_REQ);
        granted = 1;
      end
      m_busy = granted;
      if (reseed) m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
      else        m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [N_REQ+OUT_W-1:0] e;
    checks++;
    if (rand_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious: got gnt=%b rand=%b, required no grant", gnt, rand_out);
      end else begin
        e = exp_q.pop_front();
        if ({gnt, rand_out} !== e) begin
          errors++;
          $display("FAIL sb_grant: got gnt=%b rand=%b, required gnt=%b rand=%b",
                   gnt, rand_out, e[N_REQ+OUT_W-1:OUT_W], e[OUT_W-1:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      errors++;
      $display("FAIL sb_missing: got gnt=%b valid=0, required gnt=%b rand=%b",
               gnt, e[N_REQ+OUT_W-1:OUT_W], e[OUT_W-1:0]);
    end else if (gnt !== '0 || rand_out !== m_last) begin
      errors++;
      $display("FAIL sb_idle: got gnt=%b rand=%b, required gnt=0 rand=%b", gnt, rand_out, m_last);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [N_REQ-1:0] g,
                         input logic v, input logic [OUT_W-1:0] r);
    chk(name, 32'({gnt, rand_valid, rand_out}), 32'({g, v, r}));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; reseed = 1'b0; seed_in = '0;
    step(); step();
    chk_out("reset_outputs", '0, 1'b0, '0);
    rst = 1'b1;
  endtask

  logic [N_REQ-1:0] seq4 [5];
  bit hit_zero;

  initial begin
    @(negedge clk);

    // single requester: values from ACE1 then 7138
    do_reset();
    req = 4'b0001;
    step(); chk_out("t1_edge1", 4'b0001, 1'b1, 2'b01);
    step(); chk_out("t1_edge2", 4'b0000, 1'b0, 2'b01);
    step(); chk_out("t1_edge3", 4'b0001, 1'b1, 2'b00);

    // full load rotation
    do_reset();
    req = 4'b1111;
    seq4[0] = 4'b0001; seq4[1] = 4'b0010; seq4[2] = 4'b0100;
    seq4[3] = 4'b1000; seq4[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(); chk("t2_gnt", 32'(gnt), 32'(seq4[i]));
      step(); chk("t2_gap", 32'({gnt, rand_valid}), 32'h0);
    end

    // sparse requesters 1 and 3
    do_reset();
    req = 4'b1010;
    step(); chk("t3_gnt_a", 32'(gnt), 32'h2);
    step();
    step(); chk("t3_gnt_b", 32'(gnt), 32'h8);
    step();
    step(); chk("t3_gnt_c", 32'(gnt), 32'h2);
    step();

    // reseed beats arbitration; zero seed maps to SEED
    do_reset();
    step();
    reseed = 1'b1; seed_in = 16'h0001; req = 4'b0001;
    step(); chk_out("t4_reseed_nogrant", '0, 1'b0, '0);
    chk("t4_lfsr_seed", 32'(dut.lfsr_q), 32'h0001);
    reseed = 1'b0;
    step(); chk_out("t4_seed1_grant", 4'b0001, 1'b1, 2'b01);
    req = '0;
    step();
    reseed = 1'b1; seed_in = 16'h0000; req = 4'b0001;
    step(); chk("t4_reseed0_nogrant", 32'(rand_valid), 32'h0);
    reseed = 1'b0;
    step(); chk_out("t4_seed0_g1", 4'b0001, 1'b1, 2'b01);
    step();
    step(); chk_out("t4_seed0_g2", 4'b0001, 1'b1, 2'b00);

    // reset during GRANT clears outputs and pointer
    do_reset();
    req = 4'b1111;
    step(); chk_out("t5_first", 4'b0001, 1'b1, 2'b01);
    rst = 1'b0;
    step(); chk_out("t5_reset_in_grant", '0, 1'b0, '0);
    rst = 1'b1;
    step(); chk("t5_ptr_restart", 32'(gnt), 32'h1);
    step();

    // maximal period
    do_reset();
    req = '0;
    hit_zero = 0;
    for (int i = 0; i < 65535; i++) begin
      step();
      if (dut.lfsr_q == 16'h0) hit_zero = 1;
    end
    chk("t6_period", 32'(dut.lfsr_q), 32'(SEED));
    chk("t6_never_zero", 32'(hit_zero), 32'h0);

    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      req     = N_REQ'($urandom);
      reseed  = ($urandom_range(0, 15) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rst     = ($urandom_range(0, 99) != 0);
      step();
      if (gnt & (gnt - N_REQ'(1))) begin
        errors++;
        $display("FAIL onehot: got gnt=%b, required at most one bit", gnt);
      end
    end
    rst = 1'b1; req = '0; reseed = 1'b0;
    step(); step();
    chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
